// File: rtl/universal_shift_seq.sv
// ---------------------------------------------------------------------------
// universal_shift_seq
//
// Sequential universal shift register. A multi-step operation shifts or
// rotates the register by one bit per clock until it has done 'amount' steps.
// Amounts are never reduced modulo N. Every step is performed.
//
// Ports
//   clk      in   1      rising-edge clock for all state
//   reset_n  in   1      asynchronous active-low reset
//   load     in   1      parallel load, accepted only in IDLE (beats start)
//   in_data  in   N      parallel-load data
//   start    in   1      multi-step shift request, accepted only in IDLE
//   mode     in   3      0 LSL, 1 LSR, 2 ROL, 3 ROR, 4 ASR, 5-7 reserved
//   amount   in   AMT_W  number of single-bit steps
//   ser_in   in   1      fill bit for LSL (bit 0) and LSR (bit N-1)
//   q        out  N      register contents
//   busy     out  1      high while steps are being performed
//   done     out  1      one-cycle completion pulse
//   err      out  1      one-cycle pulse when start carries a reserved mode
//   ser_out  out  1      bit shifted out by the most recent step
// ---------------------------------------------------------------------------
module universal_shift_seq #(
    parameter int N     = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [N-1:0]     in_data,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic             ser_in,
    output logic [N-1:0]     q,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             ser_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_LSL = 3'd0,
        OP_LSR = 3'd1,
        OP_ROL = 3'd2,
        OP_ROR = 3'd3,
        OP_ASR = 3'd4
    } op_e;

    state_e           state, state_nxt;
    logic [2:0]       op_r, op_nxt;
    logic [AMT_W-1:0] cnt_r, cnt_nxt;
    logic [N-1:0]     q_nxt;
    logic             busy_nxt, done_nxt, err_nxt, ser_out_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            op_r    <= 3'd0;
            cnt_r   <= '0;
            q       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            ser_out <= 1'b0;
        end else begin
            state   <= state_nxt;
            op_r    <= op_nxt;
            cnt_r   <= cnt_nxt;
            q       <= q_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            ser_out <= ser_out_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        state_nxt   = state;
        op_nxt      = op_r;
        cnt_nxt     = cnt_r;
        q_nxt       = q;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        ser_out_nxt = ser_out;

        unique case (state)
            ST_IDLE: begin
                if (load) begin
                    q_nxt = in_data;
                end else if (start) begin
                    if (mode > 3'd4) begin
                        err_nxt = 1'b1;
                    end else if (amount == '0) begin
                        // Zero-length operation: complete without ever
                        // raising busy.
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        op_nxt    = mode;
                        cnt_nxt   = amount;
                        busy_nxt  = 1'b1;
                        state_nxt = ST_SHIFT;
                    end
                end
            end

            ST_SHIFT: begin
                unique case (op_e'(op_r))
                    OP_LSL: begin
                        q_nxt       = {q[N-2:0], ser_in};
                        ser_out_nxt = q[N-1];
                    end
                    OP_LSR: begin
                        q_nxt       = {ser_in, q[N-1:1]};
                        ser_out_nxt = q[0];
                    end
                    OP_ROL: begin
                        q_nxt       = {q[N-2:0], q[N-1]};
                        ser_out_nxt = q[N-1];
                    end
                    OP_ROR: begin
                        q_nxt       = {q[0], q[N-1:1]};
                        ser_out_nxt = q[0];
                    end
                    OP_ASR: begin
                        q_nxt       = {q[N-1], q[N-1:1]};
                        ser_out_nxt = q[0];
                    end
                    default: begin
                        q_nxt = q;
                    end
                endcase
                cnt_nxt = cnt_r - AMT_W'(1);
                // The edge performing the last step also leaves SHIFT.
                if (cnt_r == AMT_W'(1)) begin
                    state_nxt = ST_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule
